my_rr_arbiter_16_4_way: RTL

// Upstream selector stage for my_mux_16_4_way. Takes four 16-bit producer channels
// (valid/ready) and picks one per cycle by round-robin. It drives the mux sel, so the

---
 rtl/my_rr_arbiter_16_4_way.sv | 119 +++++++++++
 1 files changed

// File: rtl/my_rr_arbiter_16_4_way.sv
// Round-robin selector for four 16-bit valid/ready producers feeding my_mux_16_4_way, with a one-entry registered output stage.
// Optional per-channel saturating grant counters are enabled by defining MY_ARB_GRANT_CNT_EN.

module my_mux_16_4_way (
  input  logic [1:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  output logic [15:0] out
);

  always_comb begin
    unique case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

module my_rr_arbiter_16_4_way #(
  parameter logic [1:0]  PTR_RESET = 2'd0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           in_valid,
  output logic [3:0]           in_ready,
  input  logic [15:0]          in_a,
  input  logic [15:0]          in_b,
  input  logic [15:0]          in_c,
  input  logic [15:0]          in_d,
  output logic [1:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data
`ifdef MY_ARB_GRANT_CNT_EN
  ,
  output logic [4*CNT_W-1:0]   grant_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic [1:0]  ptr;
  logic [1:0]  grant_idx;
  logic [1:0]  idx;
  logic        found;
  logic        can_load;
  logic        transfer;
  logic [15:0] mux_out;

  // Scan ptr+3 down to ptr so the candidate closest to ptr is written last and wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop; a path that skips an assignment would infer a latch.
    grant_idx = ptr;
    idx       = ptr;
    found     = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (in_valid[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  assign transfer = found && can_load;
  assign sel      = grant_idx;
  assign in_ready = transfer ? (4'b0001 << grant_idx) : 4'b0000;

  my_mux_16_4_way u_mux (
    .sel (sel),
    .a   (in_a),
    .b   (in_b),
    .c   (in_c),
    .d   (in_d),
    .out (mux_out)
  );

  // A load overrides a drain in the same cycle, giving one word per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      ptr       <= PTR_RESET;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      ptr       <= grant_idx + 2'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MY_ARB_GRANT_CNT_EN
  // Counters stick at all-ones; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (transfer && grant_idx == 2'(i) &&
            grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
          grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule
